fadd_norm_round: RTL and testbench

- Post-add stage of the single-precision adder; sits directly downstream of the aligned-mantissa add core.
- Accepts sign, larger biased exponent and raw extended sum mantissa (carry, hidden, fraction, guard/round/sticky).
- Normalises iteratively (one shift per cycle), rounds to nearest-even and packs the IEEE-754 word.
- Valid/ready on both sides.
- NaN/Inf/both-zero exception cases are resolved upstream and never enter this block.

---
 rtl/fadd_norm_round.sv | 102 ++++++++++
 tb/tb_fadd_norm_round.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fadd_norm_round.sv
// fadd_norm_round: post-add normalise (one shift per cycle), round-to-nearest-even and pack for the single-precision adder.
module fadd_norm_round #(
    parameter int MAXSHIFT = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        s,
    input  logic [7:0]  e,
    input  logic [27:0] m,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);
    localparam int CW = $clog2(MAXSHIFT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAXSHIFT);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t state, state_n;
    logic sr, sr_n, sub, sub_n, ovf_n, inc;
    logic [8:0] ex, ex_n, ex_r;
    logic [27:0] mr, mr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] y_n;
    logic [24:0] sum;
    logic [7:0] field;
    assign inc = mr[2] & (mr[1] | mr[0] | mr[3]);
    assign sum = {1'b0, mr[26:3]} + {24'b0, inc};
    assign ex_r = ex + {8'b0, sum[24]};
    assign field = sub ? {7'b0, sum[23]} : ex_r[7:0];
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        state_n = state;
        sr_n = sr;
        ex_n = ex;
        mr_n = mr;
        sub_n = sub;
        cnt_n = cnt;
        y_n = y;
        ovf_n = ovf;
        case (state)
            IDLE: if (in_valid) begin
                state_n = NORM;
                sr_n = s;
                ex_n = {1'b0, e};
                mr_n = m;
                sub_n = 1'b0;
                cnt_n = '0;
            end
            NORM: if (mr == 28'd0) begin
                y_n = 32'd0;
                ovf_n = 1'b0;
                state_n = DONE;
            end else if (mr[27]) begin
                mr_n = {1'b0, mr[27:2], mr[1] | mr[0]};
                ex_n = ex + 9'd1;
                state_n = ROUND;
            end else if (mr[26]) begin
                state_n = ROUND;
            end else if (ex == 9'd1) begin
                sub_n = 1'b1;
                state_n = ROUND;
            end else begin
                mr_n = mr << 1;
                ex_n = ex - 9'd1;
                cnt_n = cnt + 1'b1;
            end
            ROUND: begin
                state_n = DONE;
                ovf_n = !sub && ex_r >= 9'd255;
                y_n = ovf_n ? {sr, 8'hFF, 23'd0} : {sr, field, sum[22:0]};
            end
            default: if (out_ready) state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr <= 1'b0;
            ex <= '0;
            mr <= '0;
            sub <= 1'b0;
            cnt <= '0;
            y <= '0;
            ovf <= 1'b0;
        end else begin
            state <= state_n;
            sr <= sr_n;
            ex <= ex_n;
            mr <= mr_n;
            sub <= sub_n;
            cnt <= cnt_n;
            y <= y_n;
            ovf <= ovf_n;
        end
    end
    // a legal upstream sum never needs more than MAXSHIFT left shifts
    assert property (@(posedge clk) disable iff (rst)
        !(state == NORM && mr != 28'd0 && !mr[27] && !mr[26] && ex != 9'd1 && cnt == CMAX));
endmodule

// File: tb/tb_fadd_norm_round.sv
// tb_fadd_norm_round: scoreboard bench for the adder normalise/round stage.
module tb_fadd_norm_round;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, s, out_valid, out_ready, ovf;
    logic [7:0] e;
    logic [27:0] m;
    logic [31:0] y;
    int checks = 0;
    int fails = 0;
    typedef struct {
        logic [31:0] y;
        logic        ovf;
        int          lat;
    } exp_t;
    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic [31:0] y;
        logic        ovf;
        int          lat;
    } op_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fadd_norm_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .e(e), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic drive(input op_t o);
        exp_t x;
        x.y = o.y;
        x.ovf = o.ovf;
        x.lat = o.lat;
        sb.push_back(x);
        @(negedge clk);
        s = o.s;
        e = o.e;
        m = o.m;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // waits for out_valid counting edges since accept; lat > 200 means timeout
    task automatic await_out(output int lat);
        lat = 0;
        while (lat <= 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic collect(output logic [31:0] oy, output logic oo, output int lat);
        await_out(lat);
        oy = y;
        oo = ovf;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        s = 1'b0;
        e = 8'd0;
        m = 28'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        checks++; if (y !== 32'd0) begin fails++; $display("FAIL reset y got %h want 00000000", y); end
        checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset ovf got %b want 0", ovf); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_ops(input string name, input op_t t[], input int n);
        logic [31:0] oy;
        logic oo;
        int lat;
        exp_t x;
        for (int i = 0; i < n; i++) begin
            drive(t[i]);
            collect(oy, oo, lat);
            x = sb.pop_front();
            checks++;
            if (oy !== x.y || oo !== x.ovf) begin
                fails++;
                $display("FAIL %s[%0d] y/ovf got %h/%b want %h/%b", name, i, oy, oo, x.y, x.ovf);
            end
            checks++;
            if (lat !== x.lat) begin
                fails++;
                $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, x.lat);
            end
        end
    endtask

    task automatic test_carry;
        op_t t[] = new[1];
        t[0] = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 2};
        test_ops("carry", t, 1);
    endtask

    task automatic test_round;
        op_t t[] = new[5];
        t[0] = '{1'b0, 8'd127, 28'h4000008, 32'h3F800001, 1'b0, 2};
        t[1] = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 2};
        t[2] = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 2};
        t[3] = '{1'b0, 8'd100, 28'h8000009, 32'h32800001, 1'b0, 2};
        t[4] = '{1'b1, 8'd100, 28'hC00000C, 32'hB2C00001, 1'b0, 2};
        test_ops("round", t, 5);
    endtask

    task automatic test_cancel;
        op_t t[] = new[2];
        t[0] = '{1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 25};
        t[1] = '{1'b1, 8'd127, 28'h0000000, 32'h00000000, 1'b0, 1};
        test_ops("cancel", t, 2);
    endtask

    task automatic test_overflow;
        op_t t[] = new[2];
        t[0] = '{1'b1, 8'd254, 28'h8000000, 32'hFF800000, 1'b1, 2};
        t[1] = '{1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 1'b1, 2};
        test_ops("overflow", t, 2);
    endtask

    task automatic test_subnormal;
        op_t t[] = new[2];
        t[0] = '{1'b0, 8'd1, 28'h2000000, 32'h00400000, 1'b0, 2};
        t[1] = '{1'b0, 8'd1, 28'h3FFFFFC, 32'h00800000, 1'b0, 2};
        test_ops("subnormal", t, 2);
    endtask

    task automatic test_stall;
        op_t o;
        exp_t x;
        int lat;
        bit ghost = 0;
        o = '{1'b0, 8'd127, 28'h4000000, 32'h3F800000, 1'b0, 2};
        drive(o);
        await_out(lat);
        x = sb.pop_front();
        checks++; if (lat !== x.lat) begin fails++; $display("FAIL stall latency got %0d want %0d", lat, x.lat); end
        for (int i = 0; i < 5; i++) begin
            s = 1'b1;
            e = 8'd200;
            m = 28'h8000000;
            in_valid = i[0];
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL stall[%0d] out_valid/in_ready got %b/%b want 1/0", i, out_valid, in_ready); end
            checks++; if (y !== x.y || ovf !== x.ovf) begin fails++; $display("FAIL stall[%0d] y/ovf got %h/%b want %h/%b", i, y, ovf, x.y, x.ovf); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL stall release out_valid/in_ready got %b/%b want 0/1", out_valid, in_ready); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid) ghost = 1;
        end
        checks++; if (ghost !== 1'b0) begin fails++; $display("FAIL stall ghost result got %b want 0", ghost); end
    endtask

    task automatic test_reset_mid;
        bit ghost = 0;
        @(negedge clk);
        s = 1'b0;
        e = 8'd127;
        m = 28'h0000008;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid in_ready/out_valid got %b/%b want 1/0", in_ready, out_valid); end
        checks++; if (y !== 32'd0 || ovf !== 1'b0) begin fails++; $display("FAIL rst_mid y/ovf got %h/%b want 00000000/0", y, ovf); end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (out_valid) ghost = 1;
        end
        checks++; if (ghost !== 1'b0) begin fails++; $display("FAIL rst_mid result emerged got %b want 0", ghost); end
    endtask

    initial begin
        test_reset;
        test_carry;
        test_round;
        test_cancel;
        test_overflow;
        test_subnormal;
        test_stall;
        test_reset_mid;
        checks++; if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard leftover got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
